// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between a variable-latency instruction
// memory and the core's fetch/decode register. Fetches sequential words, holds up
// to DEPTH {inst, pc} entries, flushes queued and in-flight work on a redirect.
// Optional build macro IFETCH_QUEUE_PERF_EN adds perf_dropped/perf_starve/perf_redirects.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
`ifdef IFETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_redirects
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [31:0]   fpc_q, fpc_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] if_rptr_q, if_rptr_d, if_wptr_q, if_wptr_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;

  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   if_pc  [MAX_OUT];

  logic          accept, has_head, pop, push, stale;
  logic [SW-1:0] credit_used;

  // Handshakes, credit check and head-entry outputs
  always_comb begin
    // Slots committed = queued entries + live (non-stale) requests in flight
    credit_used    = SW'(count_q) + SW'(outst_q) - SW'(drop_q);
    imem_req_valid = rst && !redirect_valid && (outst_q < OW'(MAX_OUT))
                     && (credit_used < SW'(DEPTH));
    imem_req_addr  = fpc_q;
    accept         = imem_req_valid && imem_req_ready;
    has_head       = (count_q != '0);
    out_valid      = has_head && !redirect_valid;
    pop            = out_valid && out_ready;
    stale          = imem_rsp_valid && (redirect_valid || (drop_q != '0));
    push           = imem_rsp_valid && !stale;
    out_inst       = has_head ? q_inst[rptr_q] : '0;
    out_pc         = has_head ? q_pc[rptr_q] : '0;
    out_pc4        = has_head ? (q_pc[rptr_q] + 32'd4) : '0;
  end

  // Next-state for fetch address, queue pointers and in-flight bookkeeping
  always_comb begin
    fpc_d     = fpc_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    if_rptr_d = if_rptr_q;
    if_wptr_d = if_wptr_q;
    outst_d   = outst_q + OW'(accept) - OW'(imem_rsp_valid);
    drop_d    = drop_q;

    if (accept) begin
      fpc_d     = fpc_q + 32'd4;
      if_wptr_d = (if_wptr_q == IW'(MAX_OUT - 1)) ? '0 : if_wptr_q + IW'(1);
    end
    if (imem_rsp_valid) begin
      if_rptr_d = (if_rptr_q == IW'(MAX_OUT - 1)) ? '0 : if_rptr_q + IW'(1);
      if (drop_q != '0) drop_d = drop_q - OW'(1);
    end
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // A redirect empties the queue and marks every outstanding request stale
    if (redirect_valid) begin
      fpc_d   = redirect_pc & ~32'd3;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      drop_d  = outst_q - OW'(imem_rsp_valid);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q     <= RESET_PC;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      if_rptr_q <= '0;
      if_wptr_q <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      fpc_q     <= fpc_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      if_rptr_q <= if_rptr_d;
      if_wptr_q <= if_wptr_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  // Entry storage; contents are only observed through valid pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wptr_q] <= imem_rsp_data;
      q_pc[wptr_q]   <= if_pc[if_rptr_q];
    end
    if (accept) if_pc[if_wptr_q] <= fpc_q;
  end

`ifdef IFETCH_QUEUE_PERF_EN
  logic [31:0] perf_dropped_q, perf_starve_q, perf_redirects_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_dropped_q   <= '0;
      perf_starve_q    <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (stale && (perf_dropped_q != '1)) perf_dropped_q <= perf_dropped_q + 32'd1;
      if (out_ready && !out_valid && (perf_starve_q != '1)) perf_starve_q <= perf_starve_q + 32'd1;
      if (redirect_valid && (perf_redirects_q != '1)) perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_dropped   = perf_dropped_q;
  assign perf_starve    = perf_starve_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: in-order memory model plus a transaction-level
// model of the instruction stream the core must see (program order, flushes).
module tb_ifetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pc4;
`ifdef IFETCH_QUEUE_PERF_EN
  logic [31:0] perf_dropped, perf_starve, perf_redirects;
  logic [31:0] m_dropped, m_starve, m_redirects;
`endif

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4)
`ifdef IFETCH_QUEUE_PERF_EN
    , .perf_dropped(perf_dropped), .perf_starve(perf_starve), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  // Memory model: accepted addresses with the cycle their response is due
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  // Stream model: expected fetch address, queued PCs, in-flight PCs with stale flags
  logic [31:0] exp_fpc;
  logic [31:0] exp_q[$];
  logic [31:0] infl_pc[$];
  bit          infl_stale[$];
  // Traces for hand-computed expectations
  logic [31:0] accepted[$];
  logic [31:0] consumed[$];
  logic        s_rv;
  logic [31:0] s_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model
  task automatic tick(input logic redir, input logic [31:0] rpc,
                      input logic oready, input logic mready);
    int   live;
    logic exp_rv, exp_ov, acc, rsp, cons, stl;
    logic [31:0] pc;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = oready;
    imem_req_ready = mready;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_addr_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    live = 0;
    foreach (infl_stale[i]) if (!infl_stale[i]) live++;
    exp_rv = !redir && (infl_pc.size() < MAX_OUT) && (exp_q.size() + live < DEPTH);
    exp_ov = (exp_q.size() > 0) && !redir;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fpc);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, exp_q[0]);
      chk("out_inst", out_inst, inst_of(exp_q[0]));
      chk("out_pc4", out_pc4, exp_q[0] + 32'd4);
    end
`ifdef IFETCH_QUEUE_PERF_EN
    chk("perf_dropped", perf_dropped, m_dropped);
    chk("perf_starve", perf_starve, m_starve);
    chk("perf_redirects", perf_redirects, m_redirects);
`endif
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    acc    = imem_req_valid && imem_req_ready;
    rsp    = imem_rsp_valid;
    cons   = exp_ov && oready;
    @(posedge clk);
    if (rsp) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      if (infl_pc.size() == 0) begin
        chk("rsp_has_request", 32'(infl_pc.size()), 32'd1);
      end else begin
        pc  = infl_pc.pop_front();
        stl = infl_stale.pop_front() || redir;
        if (!stl) exp_q.push_back(pc);
`ifdef IFETCH_QUEUE_PERF_EN
        else m_dropped++;
`endif
      end
    end
    if (cons) begin
      consumed.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      infl_pc.push_back(imem_req_addr);
      infl_stale.push_back(1'b0);
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      accepted.push_back(imem_req_addr);
      exp_fpc = exp_fpc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      foreach (infl_stale[i]) infl_stale[i] = 1'b1;
      exp_fpc = rpc & ~32'd3;
    end
`ifdef IFETCH_QUEUE_PERF_EN
    if (redir) m_redirects++;
    if (oready && !exp_ov) m_starve++;
`endif
    cyc++;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd0);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete();
    exp_q.delete(); infl_pc.delete(); infl_stale.delete();
    accepted.delete(); consumed.delete();
    exp_fpc = RESET_PC;
`ifdef IFETCH_QUEUE_PERF_EN
    m_dropped = '0; m_starve = '0; m_redirects = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c10;
    bit found;

    // Streaming, 1-cycle memory, core always ready
    do_reset();
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, '0, 1'b1, 1'b1);
      if (i == 9) c10 = consumed.size();
    end
    chk("stream_acc0", qat(accepted, 0), 32'h0);
    chk("stream_acc1", qat(accepted, 1), 32'h4);
    chk("stream_acc2", qat(accepted, 2), 32'h8);
    chk("stream_cons0", qat(consumed, 0), 32'h0);
    chk("stream_cons1", qat(consumed, 1), 32'h4);
    chk("stream_cons2", qat(consumed, 2), 32'h8);
    chk("stream_rate", 32'(consumed.size() - c10), 32'd10);

    // Fill under stall, then drain
    do_reset();
    lat = 1;
    repeat (10) tick(1'b0, '0, 1'b0, 1'b1);
    chk("fill_accepts", 32'(accepted.size()), 32'd4);
    chk("fill_req_idle", 32'(imem_req_valid), 32'd0);
    repeat (12) tick(1'b0, '0, 1'b1, 1'b1);
    chk("drain_cons0", qat(consumed, 0), 32'h0);
    chk("drain_cons1", qat(consumed, 1), 32'h4);
    chk("drain_cons2", qat(consumed, 2), 32'h8);
    chk("drain_cons3", qat(consumed, 3), 32'hC);
    chk("drain_resume", qat(accepted, 4), 32'h10);

    // Redirect with two requests outstanding
    do_reset();
    lat = 3;
    repeat (2) tick(1'b0, '0, 1'b1, 1'b1);
    chk("redir_outst", 32'(accepted.size()), 32'd2);
    tick(1'b1, 32'h103, 1'b1, 1'b1);
    accepted.delete(); consumed.delete();
    repeat (15) tick(1'b0, '0, 1'b1, 1'b1);
    chk("redir_req0", qat(accepted, 0), 32'h100);
    chk("redir_cons0", qat(consumed, 0), 32'h100);
`ifdef IFETCH_QUEUE_PERF_EN
    chk("redir_perf_dropped", perf_dropped, 32'd2);
`endif

    // Redirect in the same cycle as a response and out_ready
    do_reset();
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && infl_pc.size() == 2) found = 1'b1;
      else tick(1'b0, '0, 1'b1, 1'b1);
    end
    chk("coinc_setup", 32'(found), 32'd1);
    tick(1'b1, 32'h200, 1'b1, 1'b1);
    consumed.delete();
    repeat (15) tick(1'b0, '0, 1'b1, 1'b1);
    chk("coinc_cons0", qat(consumed, 0), 32'h200);
    chk("coinc_cons1", qat(consumed, 1), 32'h204);

    // Memory back-pressure for five cycles
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("bp_valid", 32'(s_rv), 32'd1);
      chk("bp_addr", s_addr, 32'h0);
    end
    tick(1'b0, '0, 1'b1, 1'b1);
    chk("bp_accept_addr", s_addr, 32'h0);
    tick(1'b0, '0, 1'b1, 1'b1);
    chk("bp_next_addr", s_addr, 32'h4);

    // Asynchronous reset mid-stream
    lat = 1;
    repeat (8) tick(1'b0, '0, 1'b1, 1'b1);
    do_reset();
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(s_rv), 32'd1);
    chk("post_rst_addr", s_addr, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
